// File: rtl/coffee_brew_ctrl_if.sv
// Signal bundle between the coffee brew controller and its environment.
// master drives the user/sensor inputs; slave is the controller.
interface coffee_brew_ctrl_if;
    // No valid/ready pairs here: coin, start and cancel are single-cycle
    // request pulses, sampled on the rising clock edge and never held or
    // back-pressured. cup_ok is a level. done and refund are single-cycle
    // result pulses, and refund_amt is valid while refund is high.
    logic       coin;
    logic [1:0] sel;
    logic       start;
    logic       cancel;
    logic       cup_ok;
    logic       heat;
    logic       pump;
    logic [3:0] credit;
    logic       done;
    logic       refund;
    logic [3:0] refund_amt;
    logic [2:0] state_reg;

    modport master (
        output coin, sel, start, cancel, cup_ok,
        input  heat, pump, credit, done, refund, refund_amt, state_reg
    );

    modport slave (
        input  coin, sel, start, cancel, cup_ok,
        output heat, pump, credit, done, refund, refund_amt, state_reg
    );
endinterface

// File: rtl/coffee_brew_ctrl.sv
// Coin-operated coffee brew controller: credit, preheat, timed pump, refund.
// Optional macro COFFEE_CUP_CHECK_EN pauses the pump while no cup is present.
module coffee_brew_ctrl #(
    parameter int PRICE     = 3,
    parameter int HEAT_CYC  = 8,
    parameter int SHORT_CYC = 10,
    parameter int LONG_CYC  = 20
) (
    input logic clock,
    input logic reset,
    coffee_brew_ctrl_if.slave bus
);
    localparam int CNT_MAX = (HEAT_CYC > LONG_CYC) ? HEAT_CYC : LONG_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [3:0] PRICE_V = 4'(PRICE);

`ifdef COFFEE_CUP_CHECK_EN
    localparam bit CUP_CHECK = 1'b1;
`else
    localparam bit CUP_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CREDIT = 3'd1,
        HEAT   = 3'd2,
        BREW   = 3'd3,
        DONE   = 3'd4,
        REFUND = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    sel_q;
    logic [3:0]    credit;
    logic [3:0]    refund_amt;
    logic          heat, pump, done, refund;

    logic [3:0]    credit_add;
    logic [CW-1:0] brew_last;
    logic          sel_ok;
    logic          pump_want;

    assign credit_add = (bus.coin && credit != 4'hF) ? credit + 4'd1 : credit;
    assign brew_last  = (sel_q == 2'b10) ? CW'(LONG_CYC - 1) : CW'(SHORT_CYC - 1);
    assign sel_ok     = (bus.sel == 2'b01) || (bus.sel == 2'b10);
    // Without the cup check the pump never pauses, whatever cup_ok says.
    assign pump_want  = CUP_CHECK ? bus.cup_ok : 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sel_q      <= 2'b00;
            credit     <= 4'd0;
            refund_amt <= 4'd0;
            heat       <= 1'b0;
            pump       <= 1'b0;
            done       <= 1'b0;
            refund     <= 1'b0;
        end else begin
            done   <= 1'b0;
            refund <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.coin) begin
                        credit <= credit_add;
                        state  <= CREDIT;
                    end
                end
                CREDIT: begin
                    credit <= credit_add;
                    // Price check uses credit before this cycle's coin.
                    if (bus.cancel) begin
                        refund_amt <= credit_add;
                        credit     <= 4'd0;
                        refund     <= 1'b1;
                        state      <= REFUND;
                    end else if (bus.start && credit >= PRICE_V && sel_ok) begin
                        sel_q  <= bus.sel;
                        credit <= credit - PRICE_V + {3'b000, bus.coin};
                        heat   <= 1'b1;
                        cnt    <= '0;
                        state  <= HEAT;
                    end
                end
                HEAT: begin
                    credit <= credit_add;
                    if (cnt == CW'(HEAT_CYC - 1)) begin
                        cnt   <= '0;
                        pump  <= pump_want;
                        state <= BREW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREW: begin
                    credit <= credit_add;
                    // The count only advances on cycles the pump actually ran.
                    if (!pump) begin
                        pump <= pump_want;
                    end else if (cnt == brew_last) begin
                        cnt   <= '0;
                        heat  <= 1'b0;
                        pump  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        pump <= pump_want;
                    end
                end
                DONE: begin
                    credit <= credit_add;
                    cnt    <= '0;
                    state  <= (credit_add != 4'd0) ? CREDIT : IDLE;
                end
                REFUND: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    heat  <= 1'b0;
                    pump  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.heat       = heat;
    assign bus.pump       = pump;
    assign bus.credit     = credit;
    assign bus.done       = done;
    assign bus.refund     = refund;
    assign bus.refund_amt = refund_amt;
    assign bus.state_reg  = state;
endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// Directed bench for coffee_brew_ctrl; define COFFEE_CUP_CHECK_EN for both
// files together to exercise the cup-check build.
module tb_coffee_brew_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_CREDIT = 3'd1, S_HEAT = 3'd2,
                           S_BREW = 3'd3, S_DONE = 3'd4, S_REFUND = 3'd5;
`ifdef COFFEE_CUP_CHECK_EN
    localparam int EXP_HOLD = 5;
`else
    localparam int EXP_HOLD = 0;
`endif

    logic clock;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   len;
    int   bad;

    coffee_brew_ctrl_if bus ();

    coffee_brew_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) begin
            bus.coin = 1'b1;
            step();
            bus.coin = 1'b0;
        end
    endtask

    task automatic press_start(input logic [1:0] s);
        bus.sel   = s;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Counts cycles spent in state st, tallying cycles where heat/pump differ.
    task automatic run_phase(input logic [2:0] st, input logic eh, input logic ep,
                             output int n, output int nbad);
        n = 0;
        nbad = 0;
        while (bus.state_reg === st && n < 200) begin
            if (bus.heat !== eh || bus.pump !== ep) nbad++;
            n++;
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.coin   = 1'b0;
        bus.sel    = 2'b00;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.cup_ok = 1'b1;
        step();
        step();
        chk("rst_state", bus.state_reg, S_IDLE);
        chk("rst_credit", bus.credit, 0);
        chk("rst_outs", {bus.heat, bus.pump, bus.done, bus.refund}, 0);
        chk("rst_refund_amt", bus.refund_amt, 0);
        reset = 1'b0;
        step();

        // Cancel in IDLE is ignored.
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("idle_cancel_state", bus.state_reg, S_IDLE);
        chk("idle_cancel_refund", bus.refund, 0);

        // Short cup with exact price.
        coins(1);
        chk("first_coin_state", bus.state_reg, S_CREDIT);
        coins(2);
        chk("credit3", bus.credit, 3);
        press_start(2'b01);
        chk("short_accept_state", bus.state_reg, S_HEAT);
        chk("short_accept_credit", bus.credit, 0);
        run_phase(S_HEAT, 1'b1, 1'b0, len, bad);
        chk("short_heat_len", len, 8);
        chk("short_heat_outs", bad, 0);
        run_phase(S_BREW, 1'b1, 1'b1, len, bad);
        chk("short_brew_len", len, 10);
        chk("short_brew_outs", bad, 0);
        chk("short_done_state", bus.state_reg, S_DONE);
        chk("short_done_outs", {bus.heat, bus.pump, bus.done}, 3'b001);
        step();
        chk("short_after_state", bus.state_reg, S_IDLE);
        chk("short_after_credit", bus.credit, 0);
        chk("short_after_done", bus.done, 0);

        // Long cup with one coin left over.
        coins(4);
        press_start(2'b10);
        chk("long_accept_credit", bus.credit, 1);
        run_phase(S_HEAT, 1'b1, 1'b0, len, bad);
        chk("long_heat_len", len, 8);
        run_phase(S_BREW, 1'b1, 1'b1, len, bad);
        chk("long_brew_len", len, 20);
        chk("long_brew_outs", bad, 0);
        chk("long_done", bus.done, 1);
        step();
        chk("long_after_state", bus.state_reg, S_CREDIT);
        chk("long_after_credit", bus.credit, 1);

        // Refund leftover, then short credit start ignored and cancelled.
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("refund1_amt", bus.refund_amt, 1);
        step();
        coins(2);
        press_start(2'b01);
        chk("low_credit_state", bus.state_reg, S_CREDIT);
        chk("low_credit_credit", bus.credit, 2);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("cancel_state", bus.state_reg, S_REFUND);
        chk("cancel_refund", bus.refund, 1);
        chk("cancel_amt", bus.refund_amt, 2);
        chk("cancel_credit", bus.credit, 0);
        bus.coin = 1'b1;
        step();
        bus.coin = 1'b0;
        chk("refund_coin_ignored", bus.credit, 0);
        chk("refund_to_idle", bus.state_reg, S_IDLE);
        chk("refund_pulse_end", bus.refund, 0);
        chk("refund_amt_hold", bus.refund_amt, 2);

        // Saturation, invalid selections, cancel beating start.
        coins(16);
        chk("sat_credit", bus.credit, 15);
        press_start(2'b11);
        chk("sel11_ignored", bus.state_reg, S_CREDIT);
        press_start(2'b00);
        chk("sel00_ignored", bus.state_reg, S_CREDIT);
        chk("sel_bad_credit", bus.credit, 15);
        bus.sel    = 2'b01;
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        step();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("cancel_wins_state", bus.state_reg, S_REFUND);
        chk("cancel_wins_amt", bus.refund_amt, 15);
        step();

        // Same-cycle coin with cancel and with start.
        coins(2);
        bus.coin   = 1'b1;
        bus.cancel = 1'b1;
        step();
        bus.coin   = 1'b0;
        bus.cancel = 1'b0;
        chk("cancel_coin_amt", bus.refund_amt, 3);
        step();
        coins(3);
        bus.coin = 1'b1;
        press_start(2'b01);
        bus.coin = 1'b0;
        chk("start_coin_credit", bus.credit, 1);
        run_phase(S_HEAT, 1'b1, 1'b0, len, bad);

        // Cup removed for five cycles mid-brew.
        len = 0;
        bad = 0;
        while (bus.state_reg === S_BREW && len < 200) begin
            if (len == 3) bus.cup_ok = 1'b0;
            if (len == 8) bus.cup_ok = 1'b1;
            if (bus.pump === 1'b0) bad++;
            len++;
            step();
        end
        bus.cup_ok = 1'b1;
        chk("cup_brew_len", len, 10 + EXP_HOLD);
        chk("cup_pump_low", bad, EXP_HOLD);
        chk("cup_done", bus.done, 1);
        step();
        chk("cup_after_credit", bus.credit, 1);

        // Reset mid-brew aborts asynchronously with no refund.
        coins(2);
        press_start(2'b01);
        run_phase(S_HEAT, 1'b1, 1'b0, len, bad);
        step();
        step();
        chk("pre_abort_state", bus.state_reg, S_BREW);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_state", bus.state_reg, S_IDLE);
        chk("abort_outs", {bus.heat, bus.pump, bus.done, bus.refund}, 0);
        chk("abort_credit", bus.credit, 0);
        step();
        chk("abort_no_refund", bus.refund, 0);
        reset = 1'b0;
        step();
        chk("abort_idle", bus.state_reg, S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/coffee_brew_ctrl.md
COFFEE_BREW_CTRL -- requirements
Module: coffee_brew_ctrl

Interface
REQ-001 Parameter PRICE, default 3: coins charged per cup.
REQ-002 Parameter HEAT_CYC, default 8: preheat duration in clock cycles.
REQ-003 Parameter SHORT_CYC, default 10: pump duration for short cup, in cycles.
REQ-004 Parameter LONG_CYC, default 20: pump duration for long cup, in cycles.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Port clock, input, 1: single clock, rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port coin, input, 1: one-cycle pulse, one coin unit.
REQ-009 Port sel, input, 2: 01 short, 10 long, 00/11 invalid.
REQ-010 Port start, input, 1: one-cycle pulse, request brew.
REQ-011 Port cancel, input, 1: one-cycle pulse, request refund.
REQ-012 Port cup_ok, input, 1: level, cup present under spout.
REQ-013 Port heat, output, 1: heater enable (drives coffee unit "on").
REQ-014 Port pump, output, 1: pump enable (drives coffee unit "gen").
REQ-015 Port credit, output, 4: current credit in coin units.
REQ-016 Port done, output, 1: one-cycle pulse, cup finished.
REQ-017 Port refund, output, 1: one-cycle pulse, refund_amt valid.
REQ-018 Port refund_amt, output, 4: coins returned; holds last value between refunds.
REQ-019 Port state_reg, output, 3: current FSM state encoding.

Function
REQ-020 FSM states SHALL be IDLE=0, CREDIT=1, HEAT=2, BREW=3, DONE=4, REFUND=5; encodings 6-7 SHALL return to IDLE on the next edge.
REQ-021 All outputs SHALL be registered or decoded from state_reg only (Moore); no combinational input-to-output path.
REQ-022 In IDLE and CREDIT, coin SHALL increment credit, saturating at 15; the state SHALL move from IDLE to CREDIT on the first coin.
REQ-023 Coin pulses in HEAT, BREW or DONE SHALL be added to credit, saturating at 15; coin in REFUND SHALL be ignored.
REQ-024 In CREDIT, start SHALL be accepted only if credit >= PRICE before that cycle's coin is added, and sel is 01 or 10; otherwise start is ignored.
REQ-025 On acceptance: sel latched, credit reduced by PRICE (plus any same-cycle coin), next state HEAT; heat=1 from the following cycle.
REQ-026 HEAT: heat=1, pump=0 for exactly HEAT_CYC cycles, then BREW.
REQ-027 BREW: heat=1, pump=1 for exactly SHORT_CYC or LONG_CYC cycles per the latched sel, then DONE.
REQ-028 DONE: heat=0, pump=0, done=1 for one cycle; next state CREDIT if credit > 0, else IDLE.
REQ-029 In CREDIT, cancel SHALL go to REFUND; refund_amt = credit plus any same-cycle coin; credit cleared.
REQ-030 Cancel and start asserted in the same cycle: cancel wins.
REQ-031 Cancel in IDLE, HEAT, BREW or DONE SHALL be ignored.
REQ-032 REFUND: refund=1 for one cycle, then IDLE.
REQ-033 The internal cycle counter SHALL be wide enough for max(HEAT_CYC, LONG_CYC) and SHALL be cleared on every state entry.

Reset
REQ-034 Reset assertion SHALL asynchronously force state IDLE, credit=0, refund_amt=0, heat=0, pump=0, done=0, refund=0, counter=0, latched sel=00.
REQ-035 Reset mid-brew SHALL abort immediately; credit is lost, with no refund pulse.

Configuration
REQ-036 With macro COFFEE_CUP_CHECK_EN defined, in BREW with cup_ok=0: pump=0, counter holds, heat stays 1; pumping resumes when cup_ok=1, for the remaining count.
REQ-037 Without COFFEE_CUP_CHECK_EN, cup_ok SHALL be ignored and BREW SHALL run uninterrupted.

Verification
REQ-038 Reset; 3 coins; sel=01; start -> HEAT 8 cycles heat=1 pump=0; BREW 10 cycles pump=1; done pulse; credit=0; state IDLE.
REQ-039 4 coins; sel=10; start -> BREW 20 cycles; after done state CREDIT, credit=1.
REQ-040 2 coins; start -> ignored, state stays CREDIT; cancel -> refund=1, refund_amt=2, credit=0, state IDLE.
REQ-041 16 coins -> credit saturates at 15; sel=11 with start -> ignored; cancel and start in same cycle -> refund_amt=15.
REQ-042 COFFEE_CUP_CHECK_EN defined: drop cup_ok for 5 cycles mid-BREW -> pump=0 for those 5 cycles; BREW lasts SHORT_CYC+5 cycles total.
REQ-043 Assert reset during BREW -> all outputs 0 and state IDLE without waiting for a clock edge; no refund pulse.
